// File: rtl/mux4_pkg.sv
// ---------------------------------------------------------------------------
// mux4_pkg
// Shared constants and types for the mux4 lane selector and its sub-blocks.
//   N_LANES : number of selectable lanes packed into the input bus
//   SEL_W   : width of the lane select
//   sel_t   : lane select type
//   lane_e  : symbolic lane names
// ---------------------------------------------------------------------------
package mux4_pkg;

    localparam int N_LANES = 4;
    localparam int SEL_W   = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic [SEL_W-1:0] {
        LANE0 = 2'd0,
        LANE1,
        LANE2,
        LANE3
    } lane_e;

endpackage

// File: rtl/mux4_sel_core.sv
// ---------------------------------------------------------------------------
// mux4_sel_core
// Purely combinational 4-to-1 selector of WIDTH-bit lanes.
// Ports:
//   a_i   in  N_LANES*WIDTH  packed lanes, lane k = a_i[k*WIDTH +: WIDTH]
//   sel_i in  SEL_W          lane select, unsigned
//   y_o   out WIDTH          selected lane
// ---------------------------------------------------------------------------
module mux4_sel_core
    import mux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [N_LANES*WIDTH-1:0] a_i,
    input  sel_t                     sel_i,
    output logic [WIDTH-1:0]         y_o
);

    logic [WIDTH-1:0] lanes [N_LANES];

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        assign lanes[k] = a_i[k*WIDTH +: WIDTH];
    end

    // Array indexing rather than a case statement so an unknown select
    // propagates as X instead of silently picking a default lane.
    assign y_o = lanes[sel_i];

endmodule

// File: rtl/mux4.sv
// ---------------------------------------------------------------------------
// mux4
// 4-to-1 lane selector with a combinational output for glue logic and a
// registered copy (valid flag, select-change pulse, optional parity) for
// pipelined consumers.
// Build option: define MUX4_PARITY_EN to build the registered parity bit;
// otherwise PAR is tied to 0.
// Ports:
//   clk     in  1          rising-edge clock
//   rst_n   in  1          synchronous active-low reset
//   A       in  4*WIDTH    packed lanes, lane k = A[k*WIDTH +: WIDTH]
//   SEL     in  2          lane select
//   EN      in  1          capture enable for the registered path
//   OUT     out WIDTH      combinational selected lane
//   OUT_Q   out WIDTH      registered selected lane
//   OUT_VLD out 1          OUT_Q holds a captured value
//   SEL_CHG out 1          one-cycle pulse: captured SEL differs from previous
//   PAR     out 1          even parity of OUT_Q (0 when parity not built)
// ---------------------------------------------------------------------------
module mux4
    import mux4_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_LANES*WIDTH-1:0] A,
    input  sel_t                     SEL,
    input  logic                     EN,
    output logic [WIDTH-1:0]         OUT,
    output logic [WIDTH-1:0]         OUT_Q,
    output logic                     OUT_VLD,
    output logic                     SEL_CHG,
    output logic                     PAR
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             vld_q, vld_d;
    logic             chg_q, chg_d;
    sel_t             sel_q, sel_d;

    mux4_sel_core #(
        .WIDTH (WIDTH)
    ) u_sel_core (
        .a_i   (A),
        .sel_i (SEL),
        .y_o   (OUT)
    );

    // Next-state for the capture path. Everything holds when EN is low
    // except the change flag, which must fall back to 0 so it stays a pulse.
    // The change flag is gated by the old valid flag so the first capture
    // after reset never compares against the reset value of sel_q.
    always_comb begin
        out_d = out_q;
        vld_d = vld_q;
        sel_d = sel_q;
        chg_d = 1'b0;
        if (EN) begin
            out_d = OUT;
            vld_d = 1'b1;
            chg_d = vld_q && (SEL != sel_q);
            sel_d = SEL;
        end
    end

    // Capture registers; reset takes priority over EN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
            vld_q <= 1'b0;
            chg_q <= 1'b0;
            sel_q <= LANE0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
            chg_q <= chg_d;
            sel_q <= sel_d;
        end
    end

    assign OUT_Q   = out_q;
    assign OUT_VLD = vld_q;
    assign SEL_CHG = chg_q;

`ifdef MUX4_PARITY_EN
    logic par_q, par_d;

    // Parity is taken from the same value being captured into OUT_Q so the
    // two can never disagree.
    always_comb begin
        par_d = par_q;
        if (EN) begin
            par_d = ^OUT;
        end
    end

    // Parity register, cleared with the rest of the capture path.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign PAR = par_q;
`else
    assign PAR = 1'b0;
`endif

endmodule

// File: tb/tb_mux4.sv
// ---------------------------------------------------------------------------
// tb_mux4
// Directed bench for mux4: a WIDTH=1 instance and a WIDTH=8 instance share
// the clock and reset; each has its own data, select and enable.
// ---------------------------------------------------------------------------
module tb_mux4;

    logic       clk;
    logic       rst_n;

    logic [3:0] a1;
    logic [1:0] sel1;
    logic       en1;
    logic       out1, outq1, vld1, chg1, par1;

    logic [31:0] a8;
    logic [1:0]  sel8;
    logic        en8;
    logic [7:0]  out8, outq8;
    logic        vld8, chg8, par8;

    int checks = 0;
    int errors = 0;

    mux4 #(.WIDTH(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (a1),
        .SEL     (sel1),
        .EN      (en1),
        .OUT     (out1),
        .OUT_Q   (outq1),
        .OUT_VLD (vld1),
        .SEL_CHG (chg1),
        .PAR     (par1)
    );

    mux4 #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (a8),
        .SEL     (sel8),
        .EN      (en8),
        .OUT     (out8),
        .OUT_Q   (outq8),
        .OUT_VLD (vld8),
        .SEL_CHG (chg8),
        .PAR     (par8)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected PAR for a captured value, depending on the build.
    function automatic logic parExp(input logic [7:0] v);
`ifdef MUX4_PARITY_EN
        return ^v;
`else
        return 1'b0 & v[0];
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive inputs of the WIDTH=1 instance.
    task automatic applyStimulus(input logic rst, input logic en,
                                 input logic [3:0] a, input logic [1:0] sel);
        rst_n = rst;
        en1   = en;
        a1    = a;
        sel1  = sel;
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkRegs1(input string tag, input logic q, input logic v,
                              input logic c, input logic p);
        checkOutput({tag, ".q"},   8'(outq1), 8'(q));
        checkOutput({tag, ".vld"}, 8'(vld1),  8'(v));
        checkOutput({tag, ".chg"}, 8'(chg1),  8'(c));
        checkOutput({tag, ".par"}, 8'(par1),  8'(p));
    endtask

    task automatic checkRegs8(input string tag, input logic [7:0] q,
                              input logic v, input logic c, input logic p);
        checkOutput({tag, ".q"},   outq8,    q);
        checkOutput({tag, ".vld"}, 8'(vld8), 8'(v));
        checkOutput({tag, ".chg"}, 8'(chg8), 8'(c));
        checkOutput({tag, ".par"}, 8'(par8), 8'(p));
    endtask

    initial begin
        en8  = 1'b0;
        sel8 = 2'b00;
        a8   = {8'hA5, 8'h3C, 8'h0F, 8'hF0};
        applyStimulus(1'b0, 1'b0, 4'b1010, 2'b11);

        // Combinational path stepped without relying on clock edges.
        #10 checkOutput("comb_sel11", 8'(out1), 8'd1);
        sel1 = 2'b10;
        #10 checkOutput("comb_sel10", 8'(out1), 8'd0);
        sel1 = 2'b01;
        #10 checkOutput("comb_sel01", 8'(out1), 8'd1);
        sel1 = 2'b00;
        #10 checkOutput("comb_sel00", 8'(out1), 8'd0);

        // Two reset cycles, then idle with EN low.
        @(negedge clk);
        tick();
        tick();
        checkRegs1("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        checkRegs8("reset8", 8'h00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'b1010, 2'b01);
        tick();
        checkRegs1("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("idle_comb", 8'(out1), 8'd1);

        // Captures: SEL 11, 11, 01.
        applyStimulus(1'b1, 1'b1, 4'b1010, 2'b11);
        tick();
        checkRegs1("cap1", 1'b1, 1'b1, 1'b0, parExp(8'd1));
        tick();
        checkRegs1("cap2", 1'b1, 1'b1, 1'b0, parExp(8'd1));
        sel1 = 2'b01;
        tick();
        checkRegs1("cap3", 1'b1, 1'b1, 1'b1, parExp(8'd1));

        // EN low while inputs toggle: registers hold, pulse drops.
        applyStimulus(1'b1, 1'b0, 4'b0101, 2'b00);
        #1 checkOutput("hold_comb", 8'(out1), 8'd1);
        sel1 = 2'b01;
        #1 checkOutput("hold_comb2", 8'(out1), 8'd0);
        @(negedge clk);
        tick();
        checkRegs1("hold", 1'b1, 1'b1, 1'b0, parExp(8'd1));

        // Wide instance: first capture, then select change, then odd parity.
        en8  = 1'b1;
        sel8 = 2'b10;
        #1 checkOutput("w8_comb", out8, 8'h3C);
        @(negedge clk);
        tick();
        checkRegs8("w8_cap1", 8'h3C, 1'b1, 1'b0, parExp(8'h3C));
        sel8 = 2'b11;
        tick();
        checkRegs8("w8_cap2", 8'hA5, 1'b1, 1'b1, parExp(8'hA5));
        sel8 = 2'b00;
        a8   = {8'hA5, 8'h3C, 8'h0F, 8'h07};
        tick();
        checkRegs8("w8_cap3", 8'h07, 1'b1, 1'b1, parExp(8'h07));
        en8 = 1'b0;
        a8  = {8'h11, 8'h22, 8'h33, 8'h44};
        tick();
        checkRegs8("w8_hold", 8'h07, 1'b1, 1'b0, parExp(8'h07));
        checkOutput("w8_comb2", out8, 8'h44);

        // Reset coinciding with EN=1 after valid data.
        en8 = 1'b1;
        applyStimulus(1'b0, 1'b1, 4'b0101, 2'b11);
        tick();
        checkRegs1("rst_en", 1'b0, 1'b0, 1'b0, 1'b0);
        checkRegs8("rst_en8", 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("rst_comb", 8'(out1), 8'd0);

        // First capture after reset: no change pulse although SEL differs.
        applyStimulus(1'b1, 1'b1, 4'b0101, 2'b10);
        sel8 = 2'b01;
        tick();
        checkRegs1("post_rst", 1'b1, 1'b1, 1'b0, parExp(8'd1));
        checkRegs8("post_rst8", 8'h33, 1'b1, 1'b0, parExp(8'h33));
        sel1 = 2'b00;
        tick();
        checkRegs1("post_rst2", 1'b1, 1'b1, 1'b1, parExp(8'd1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux4.md
Name: mux4

Overview:
4-to-1 selector of WIDTH-bit lanes packed into bus A, chosen by 2-bit SEL.
- Provides a purely combinational output OUT for glue logic.
- Also provides a registered copy OUT_Q with a valid flag and a select-change pulse, for pipelined consumers in the datapath.
- Leaf block; no handshake back-pressure.

Parameters:
WIDTH, 1, bit width of each of the 4 input lanes and of OUT/OUT_Q.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- A  in  4*WIDTH  packed inputs; lane k = A[k*WIDTH +: WIDTH], k=0..3
- SEL  in  2  lane select, unsigned
- EN  in  1  capture enable for the registered path
- OUT  out  WIDTH  combinational selected lane
- OUT_Q  out  WIDTH  registered selected lane
- OUT_VLD  out  1  OUT_Q holds a captured value
- SEL_CHG  out  1  one-cycle pulse: captured SEL differs from previous capture
- PAR  out  1  parity of OUT_Q (see Optional Feature)

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst_n). All registers are sampled on the rising edge of clk only.
- OUT = lane SEL of A, zero latency, independent of clk/rst_n/EN:
  - SEL=00 -> A lane 0
  - SEL=01 -> lane 1
  - SEL=10 -> lane 2
  - SEL=11 -> lane 3
- WIDTH=1 example: A=4'b1010 gives OUT: SEL=11 -> 1, SEL=10 -> 0, SEL=01 -> 1, SEL=00 -> 0.
- X/Z on SEL or the selected lane propagates to OUT. Unselected lanes never affect OUT.
- Reset (rst_n=0 at edge): OUT_Q=0, OUT_VLD=0, SEL_CHG=0, internal sel_q=2'b00, PAR=0. Reset wins over EN.
- Edge with rst_n=1, EN=1:
  - OUT_Q <= OUT
  - OUT_VLD <= 1
  - SEL_CHG <= OUT_VLD && (SEL != sel_q)
  - sel_q <= SEL
  - Latency of the registered path is 1 cycle.
- Edge with rst_n=1, EN=0:
  - OUT_Q, OUT_VLD, sel_q hold.
  - SEL_CHG <= 0 (it is a single-cycle pulse).
- First capture after reset never raises SEL_CHG, because OUT_VLD was 0.
- Once OUT_VLD=1 it stays 1 until the next reset.
- Reset asserted mid-stream clears all registered state on that edge; OUT keeps tracking its inputs.

Optional Feature:
MUX4_PARITY_EN
- Defined: PAR is a registered even-parity bit, PAR <= ^OUT at every EN=1 capture, so PAR always matches ^OUT_Q. PAR resets to 0.
- Undefined: PAR is tied to 0 and no parity logic is built.
- OUT, OUT_Q, OUT_VLD and SEL_CHG are identical in both builds.

Decomposition:
- Shared package mux4_pkg:
  - localparam N_LANES=4
  - localparam SEL_W=2
  - typedef sel_t (logic [SEL_W-1:0])
  - enum lane_e {LANE0=0, LANE1, LANE2, LANE3}
- Natural sub-module: mux4_sel_core, the combinational WIDTH-parameterised lane selector.
- The top level adds the capture registers, change detect and optional parity.

Test Plan:
- WIDTH=1, A=4'b1010; SEL stepped 11,10,01,00 every 10 time units with no clock -> OUT = 1,0,1,0.
- rst_n=0 for 2 cycles, then rst_n=1, EN=0 -> OUT_Q=0, OUT_VLD=0, SEL_CHG=0, PAR=0 throughout; OUT still follows A/SEL.
- rst_n=1, EN=1, A=4'b1010, SEL=11 then 11 then 01 on consecutive cycles:
  - OUT_Q = 1,1,1 one cycle after each capture
  - OUT_VLD = 1 after the first edge
  - SEL_CHG = 0,0,1
- EN=0 while A and SEL toggle -> OUT changes; OUT_Q and OUT_VLD hold; SEL_CHG=0.
- WIDTH=8, A={8'hA5,8'h3C,8'h0F,8'hF0}, SEL=10 with EN=1 -> OUT=8'h3C; OUT_Q=8'h3C next cycle; with MUX4_PARITY_EN, PAR=0. Then SEL=11 -> OUT_Q=8'hA5, PAR=0.
- Reset asserted in the same cycle as EN=1 after valid data -> OUT_Q=0 and OUT_VLD=0 on that edge; the next capture gives SEL_CHG=0.
